// File: rtl/vdas_pkg.sv
// Shared constants for the VDAS sample framing path: frame sync byte and
// the framer FSM state encoding.
package vdas_pkg;

  typedef logic [2:0] state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  localparam state_t IDLE  = 3'd0;
  localparam state_t SYNC  = 3'd1;
  localparam state_t ID    = 3'd2;
  localparam state_t CNT   = 3'd3;
  localparam state_t FETCH = 3'd4;
  localparam state_t HI    = 3'd5;
  localparam state_t LO    = 3'd6;
  localparam state_t CSUM  = 3'd7;

endpackage

// File: rtl/sample_framer.sv
// Packs samples popped from an upstream queue into byte frames for a tx queue.
// Define SAMPLE_FRAMER_CHECKSUM_EN to append an XOR checksum byte to each frame.
module sample_framer
  import vdas_pkg::*;
#(
  parameter int          NBITS     = 12,
  parameter int          FRAME_LEN = 16,
  parameter logic [7:0]  CHAN_ID   = 8'h00
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [NBITS-1:0] in,
  input  logic             em,
  output logic             pp,
  input  logic             full,
  output logic [7:0]       out,
  output logic             ld,
  output logic             busy
);

  localparam logic [7:0] FLEN = 8'(FRAME_LEN);

  state_t           state;
  state_t           nxt;
  logic [7:0]       smp_cnt;
  logic [NBITS-1:0] hold;
  logic [15:0]      hold_ext;
  logic [7:0]       byte_val;
  logic             emit;
`ifdef SAMPLE_FRAMER_CHECKSUM_EN
  logic [7:0]       csum;
`endif

  assign hold_ext = 16'(hold);

  // The byte on out is a function of state alone, so it can only move on a
  // state change and stays put while full stalls the handshake.
  always_comb begin
    nxt      = state;
    byte_val = 8'h00;
    emit     = 1'b0;
    pp       = 1'b0;
    case (state)
      IDLE:  if (en && !em) nxt = SYNC;
      SYNC:  begin byte_val = SYNC_BYTE; emit = 1'b1; if (!full) nxt = ID;  end
      ID:    begin byte_val = CHAN_ID;   emit = 1'b1; if (!full) nxt = CNT; end
      CNT:   begin byte_val = FLEN;      emit = 1'b1; if (!full) nxt = FETCH; end
      FETCH: if (!em) begin pp = 1'b1; nxt = HI; end
      HI:    begin byte_val = hold_ext[15:8]; emit = 1'b1; if (!full) nxt = LO; end
      LO: begin
        byte_val = hold_ext[7:0];
        emit     = 1'b1;
        if (!full) begin
          if (smp_cnt < FLEN) nxt = FETCH;
`ifdef SAMPLE_FRAMER_CHECKSUM_EN
          else                nxt = CSUM;
`else
          else                nxt = IDLE;
`endif
        end
      end
`ifdef SAMPLE_FRAMER_CHECKSUM_EN
      CSUM:  begin byte_val = csum; emit = 1'b1; if (!full) nxt = IDLE; end
`endif
      default: nxt = IDLE;
    endcase
  end

  assign out  = byte_val;
  assign ld   = emit & ~full;
  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      smp_cnt <= 8'h00;
      hold    <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && nxt == SYNC) begin
        smp_cnt <= 8'h00;
      end else if (pp) begin
        smp_cnt <= smp_cnt + 8'h01;
        hold    <= in;
      end
    end
  end

`ifdef SAMPLE_FRAMER_CHECKSUM_EN
  // Checksum covers everything after the sync byte, up to the checksum itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum <= 8'h00;
    end else if (state == IDLE && nxt == SYNC) begin
      csum <= 8'h00;
    end else if (ld && (state == ID || state == CNT || state == HI || state == LO)) begin
      csum <= csum ^ out;
    end
  end
`endif

endmodule

// File: tb/tb_sample_framer.sv
// Directed bench for sample_framer (FRAME_LEN=2, CHAN_ID=8'h03); expectations
// follow SAMPLE_FRAMER_CHECKSUM_EN when it is defined for the build.
module tb_sample_framer;

  localparam int NB = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          en = 1'b0;
  logic          full = 1'b0;
  logic [NB-1:0] in;
  logic          em;
  logic          pp;
  logic [7:0]    out;
  logic          ld;
  logic          busy;

  logic [NB-1:0] qmem [0:3];
  int            qidx = 0;
  int            qlen = 0;

  int            n_checks = 0;
  int            n_fail = 0;
  logic [7:0]    logb [0:31];
  int            log_n, ld_cnt, pp_cnt, ld_full_bad;
  logic          ld_s, pp_s, busy_s, pop_pend;
  logic [7:0]    out_s;
  logic [7:0]    exp_b [0:7];
  int            exp_n;

  assign em = (qidx >= qlen);
  assign in = qmem[qidx[1:0]];

  sample_framer #(.NBITS(NB), .FRAME_LEN(2), .CHAN_ID(8'h03)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in(in), .em(em), .pp(pp),
    .full(full), .out(out), .ld(ld), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Sample at the falling edge, let the DUT clock, then retire a pop 1ns later.
  task automatic tick();
    @(negedge clk);
    ld_s = ld; pp_s = pp; busy_s = busy; out_s = out;
    if (ld) begin
      if (log_n < 32) logb[log_n] = out;
      log_n++;
      ld_cnt++;
      if (full) ld_full_bad++;
    end
    if (pp) pp_cnt++;
    pop_pend = pp;
    @(posedge clk);
    #1;
    if (pop_pend) qidx++;
  endtask

  task automatic clear_log();
    log_n = 0; ld_cnt = 0; pp_cnt = 0; ld_full_bad = 0;
  endtask

  task automatic load_q(input int n);
    qmem[0] = 12'h123; qmem[1] = 12'hABC; qmem[2] = 12'h000; qmem[3] = 12'h000;
    qidx = 0; qlen = n;
  endtask

  task automatic start_frame();
    en = 1'b1;
    tick();
    en = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    do begin tick(); k++; end while (busy_s && k < 300);
    check({tag, "_done"}, {31'b0, busy_s}, 32'd0);
  endtask

  task automatic wait_pp(input string tag);
    int k = 0;
    do begin tick(); k++; end while (!pp_s && k < 300);
    check({tag, "_pp_seen"}, {31'b0, pp_s}, 32'd1);
  endtask

  task automatic check_frame(input string tag);
    check({tag, "_ld_cnt"}, ld_cnt, exp_n);
    check({tag, "_pp_cnt"}, pp_cnt, 2);
    check({tag, "_ld_while_full"}, ld_full_bad, 0);
    for (int i = 0; i < exp_n; i++)
      check($sformatf("%s_b%0d", tag, i), (i < log_n) ? {24'b0, logb[i]} : 32'hFFFF_FFFF,
            {24'b0, exp_b[i]});
  endtask

  initial begin
    exp_b = '{8'hA5, 8'h03, 8'h02, 8'h01, 8'h23, 8'h0A, 8'hBC, 8'h95};
`ifdef SAMPLE_FRAMER_CHECKSUM_EN
    exp_n = 8;
`else
    exp_n = 7;
`endif
    clear_log();
    load_q(0);

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    check("rst_pp", {31'b0, pp}, 0);
    check("rst_ld", {31'b0, ld}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_out", {24'b0, out}, 0);
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;

    // en with an empty queue must not start a frame
    clear_log();
    en = 1'b1;
    repeat (5) tick();
    en = 1'b0;
    check("idle_em_busy", {31'b0, busy_s}, 0);
    check("idle_em_ld", ld_cnt, 0);
    check("idle_em_pp", pp_cnt, 0);

    // Plain frame
    clear_log(); load_q(2);
    start_frame();
    wait_idle("f1");
    check_frame("f1");

    // Downstream full held for 5 cycles while the high byte of sample 0 waits
    clear_log(); load_q(2);
    start_frame();
    wait_pp("stall");
    full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("stall_ld_%0d", i), {31'b0, ld_s}, 0);
      check($sformatf("stall_out_%0d", i), {24'b0, out_s}, 32'h01);
    end
    full = 1'b0;
    wait_idle("stall");
    check_frame("stall");

    // Upstream empty after the first sample
    clear_log(); load_q(1);
    start_frame();
    wait_pp("starve");
    tick(); tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("starve_pp_%0d", i), {31'b0, pp_s}, 0);
      check($sformatf("starve_busy_%0d", i), {31'b0, busy_s}, 1);
    end
    qlen = 2;
    wait_idle("starve");
    check_frame("starve");

    // Reset right after the ID byte
    clear_log(); load_q(2);
    start_frame();
    begin
      int k = 0;
      do begin tick(); k++; end while (!(ld_s && out_s == 8'h03) && k < 50);
      check("mid_id_seen", {31'b0, ld_s}, 1);
    end
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_pp", {31'b0, pp}, 0);
    check("mid_rst_ld", {31'b0, ld}, 0);
    check("mid_rst_busy", {31'b0, busy}, 0);
    check("mid_rst_out", {24'b0, out}, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    clear_log(); load_q(2);
    start_frame();
    wait_idle("after_rst");
    check_frame("after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sample_framer.md
SAMPLE_FRAMER -- requirements
Module: sample_framer

Interface
REQ-001 SHALL have parameter NBITS, default 12, sample width (9..16).
REQ-002 SHALL have parameter FRAME_LEN, default 16, samples per frame (1..255).
REQ-003 SHALL have parameter CHAN_ID, default 8'h00, channel identifier byte.
REQ-004 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port en  input  1  frame start enable.
REQ-007 SHALL have port in  input  NBITS  head sample of the upstream sample queue.
REQ-008 SHALL have port em  input  1  upstream queue empty.
REQ-009 SHALL have port pp  output  1  one-cycle pop strobe to the upstream queue.
REQ-010 SHALL have port full  input  1  downstream tx byte queue full.
REQ-011 SHALL have port out  output  8  byte to the tx queue.
REQ-012 SHALL have port ld  output  1  one-cycle load strobe to the tx queue.
REQ-013 SHALL have port busy  output  1  high while a frame is in progress.

Function
REQ-014 SHALL emit each frame as: 8'hA5, CHAN_ID, FRAME_LEN, then per sample a high byte {zero-pad, in[NBITS-1:8]} and a low byte in[7:0], then an optional checksum byte.
REQ-015 SHALL use FSM states IDLE, SYNC, ID, CNT, FETCH, HI, LO, CSUM.
REQ-016 SHALL move IDLE->SYNC only when en=1 and em=0, sampled in the same cycle.
REQ-017 In SYNC, ID, CNT, HI, LO and CSUM, SHALL drive out and pulse ld for exactly one cycle when full=0, then advance; while full=1 SHALL hold the state with ld=0.
REQ-018 In FETCH with em=0, SHALL pulse pp for one cycle, capture in into a holding register on that same edge, and go to HI.
REQ-019 In FETCH with em=1, SHALL wait indefinitely with pp=0 (no timeout, no partial-frame abort).
REQ-020 After LO, SHALL go to FETCH while the sample count is below FRAME_LEN; otherwise to CSUM (macro set) or IDLE.
REQ-021 SHALL count samples with an 8-bit counter, cleared on entry to SYNC and incremented on each pp.
REQ-022 SHALL issue exactly FRAME_LEN pp pulses and exactly 3+2*FRAME_LEN(+1) ld pulses per frame.
REQ-023 SHALL have en sampled only in IDLE; deasserting en mid-frame SHALL NOT truncate the frame.
REQ-024 SHALL permit back-to-back frames: CSUM/LO->IDLE->SYNC, minimum one idle cycle.
REQ-025 SHALL hold busy=1 in every state except IDLE.
REQ-026 SHALL have out change only on a state change and be stable whenever ld=1.

Reset
REQ-027 On rst_n=0, SHALL asynchronously force state IDLE, pp=0, ld=0, busy=0, out=8'h00, counter=0, holding register=0, checksum=0.
REQ-028 Reset mid-frame SHALL abort the frame; no further bytes of it SHALL be emitted after release.

Configuration
REQ-029 With macro SAMPLE_FRAMER_CHECKSUM_EN defined, SHALL append CSUM = XOR of every emitted byte after 8'hA5 (ID, CNT, all payload bytes).
REQ-030 Without SAMPLE_FRAMER_CHECKSUM_EN, SHALL omit the CSUM state, the checksum register and the checksum byte.

Structure
REQ-031 SHALL take the sync constant 8'hA5 and the FSM state encoding from the shared package vdas_pkg.
REQ-032 SHALL be a single module with no sub-modules.

Verification
REQ-033 FRAME_LEN=2, CHAN_ID=8'h03, macro on, queue holding 12'h123 and 12'hABC, en=1, full=0 -> out bytes A5 03 02 01 23 0A BC 95, 8 ld pulses, 2 pp pulses.
REQ-034 Same stimulus, macro off -> A5 03 02 01 23 0A BC, 7 ld pulses.
REQ-035 full=1 for 5 cycles during HI -> ld held low, byte 01 emitted once after full drops, no byte lost or duplicated.
REQ-036 em=1 after the first sample for 10 cycles -> FSM waits in FETCH, pp=0, busy=1; frame completes correctly once 12'hABC arrives.
REQ-037 rst_n pulsed low after the ID byte -> all outputs 0 at once; after release with en=1, a fresh frame starts with A5.
REQ-038 en=1 with em=1 -> stays in IDLE, busy=0, no ld or pp pulses.
